// File: rtl/bp_fe_pkg.sv
// bp_fe_pkg: shared types and constants for the front-end instruction packer.
//   - bp_params_e          processor configuration selector
//   - vaddr/instr widths   widths supplied by the default configuration
//   - bp_fe_packed_word_s  one packed, 32-bit-aligned output word {mask, addr, data}
//   - packer_queue_depth_gp output queue depth (4)
//   - make_word()          builds a packed word with masked-off halves forced to zero
package bp_fe_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int vaddr_width_gp        = 39;
    localparam int instr_width_gp        = 32;
    localparam int cinstr_width_gp       = 16;
    localparam int packer_queue_depth_gp = 4;
    localparam int packer_ptr_width_gp   = 2;

    typedef struct packed {
        logic [1:0]                mask;
        logic [vaddr_width_gp-1:0] addr;
        logic [instr_width_gp-1:0] data;
    } bp_fe_packed_word_s;

    // Virtual address width for a given configuration.
    function automatic int bp_cfg_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

    // Build a packed word; a half whose mask bit is clear is driven as zero
    // so stale parcel bits never leak into the aligned store.
    function automatic bp_fe_packed_word_s make_word(
        input logic [1:0]                mask,
        input logic [vaddr_width_gp-1:0] addr,
        input logic [instr_width_gp-1:0] data
    );
        bp_fe_packed_word_s w;
        w.mask = mask;
        w.addr = addr;
        w.data = data & {{16{mask[1]}}, {16{mask[0]}}};
        return w;
    endfunction

endpackage

// File: rtl/bp_fe_packer_queue.sv
// bp_fe_packer_queue: 4-entry circular buffer of packed words.
//   clk_i, reset_i  clock, synchronous active-high reset (drops all entries)
//   enq_cnt_i       number of words enqueued this cycle (0, 1 or 2)
//   enq0_i, enq1_i  oldest / second word to enqueue
//   deq_i           consumer takes the head word this cycle
//   head_v_o        head word valid
//   head_o          head word (all zero when empty)
//   free_cnt_o      free entries based on registered occupancy only
//   empty_o         no entries held
module bp_fe_packer_queue
    import bp_fe_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [1:0]         enq_cnt_i,
    input  bp_fe_packed_word_s enq0_i,
    input  bp_fe_packed_word_s enq1_i,
    input  logic               deq_i,
    output logic               head_v_o,
    output bp_fe_packed_word_s head_o,
    output logic [2:0]         free_cnt_o,
    output logic               empty_o
);

    bp_fe_packed_word_s               mem_r [packer_queue_depth_gp];
    logic [packer_ptr_width_gp-1:0]   rd_ptr_r;
    logic [packer_ptr_width_gp-1:0]   wr_ptr_r;
    logic [packer_ptr_width_gp-1:0]   wr_ptr_nx1_s;
    logic [2:0]                       count_r;
    logic [1:0]                       enq_cnt_s;
    logic                             deq_s;

    // Clamp the enqueue count to the two write ports and gate dequeue on occupancy.
    always_comb begin
        enq_cnt_s    = 2'd0;
        wr_ptr_nx1_s = wr_ptr_r + 2'd1;
        deq_s        = deq_i & (count_r != 3'd0);
        if (enq_cnt_i == 2'd3) begin
            enq_cnt_s = 2'd2;
        end else begin
            enq_cnt_s = enq_cnt_i;
        end
    end

    // Storage, pointers (2-bit, wrapping naturally) and occupancy counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= 2'd0;
            wr_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            for (int i = 0; i < packer_queue_depth_gp; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (enq_cnt_s != 2'd0) begin
                mem_r[wr_ptr_r] <= enq0_i;
            end
            if (enq_cnt_s == 2'd2) begin
                mem_r[wr_ptr_nx1_s] <= enq1_i;
            end
            wr_ptr_r <= wr_ptr_r + enq_cnt_s;
            rd_ptr_r <= rd_ptr_r + {1'b0, deq_s};
            count_r  <= count_r + {1'b0, enq_cnt_s} - {2'b00, deq_s};
        end
    end

    // Head presentation; an empty queue shows an all-zero word.
    always_comb begin
        head_v_o   = (count_r != 3'd0);
        free_cnt_o = 3'd4 - count_r;
        empty_o    = (count_r == 3'd0);
        if (head_v_o) begin
            head_o = mem_r[rd_ptr_r];
        end else begin
            head_o = '0;
        end
    end

endmodule

// File: rtl/bp_fe_packer.sv
// bp_fe_packer: packs a stream of 16/32-bit instructions into 32-bit-aligned
// words with per-half valid masks, holding a straddling upper half between words.
//   clk_i, reset_i          clock, synchronous active-high reset
//   instr_v_i, instr_i, pc_i, instr_ready_and_o   instruction input handshake
//   flush_i                 level request to emit any pending half
//   word_v_o, word_o, word_addr_o, word_mask_o, word_ready_and_i   packed output
//   partial_v_o, partial_instr_o, partial_pc_o   pending half in resume format
//   idle_o                  no pending half and queue empty
// Optional feature macro BP_FE_PACKER_RESUME_EN: when defined the partial_*
// outputs expose the pending register; otherwise they are tied to zero.
module bp_fe_packer
    import bp_fe_pkg::*;
#(
    parameter bp_params_e bp_params_p   = e_bp_default_cfg,
    localparam int        vaddr_width_p = bp_cfg_vaddr_width(bp_params_p)
)
(
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       instr_v_i,
    input  logic [instr_width_gp-1:0]  instr_i,
    input  logic [vaddr_width_p-1:0]   pc_i,
    output logic                       instr_ready_and_o,
    input  logic                       flush_i,
    output logic                       word_v_o,
    output logic [instr_width_gp-1:0]  word_o,
    output logic [vaddr_width_p-1:0]   word_addr_o,
    output logic [1:0]                 word_mask_o,
    input  logic                       word_ready_and_i,
    output logic                       partial_v_o,
    output logic [cinstr_width_gp-1:0] partial_instr_o,
    output logic [vaddr_width_p-1:0]   partial_pc_o,
    output logic                       idle_o
);

    localparam logic [vaddr_width_p-1:0] half_step_lp = vaddr_width_p'(3'd2);
    localparam logic [vaddr_width_p-1:0] word_step_lp = vaddr_width_p'(3'd4);

    logic                       pend_v_r;
    logic [cinstr_width_gp-1:0] pend_data_r;
    logic [vaddr_width_p-1:0]   pend_addr_r;
    logic                       pend_v_nxt_s;
    logic [cinstr_width_gp-1:0] pend_data_nxt_s;
    logic [vaddr_width_p-1:0]   pend_addr_nxt_s;

    logic                       ready_s;
    logic                       accept_s;
    logic                       compressed_s;
    logic                       contig_s;
    logic                       drop_v_s;
    logic                       main_v_s;
    bp_fe_packed_word_s         drop_word_s;
    bp_fe_packed_word_s         main_word_s;
    bp_fe_packed_word_s         enq0_s;
    bp_fe_packed_word_s         enq1_s;
    logic [1:0]                 enq_cnt_s;
    logic [2:0]                 free_cnt_s;
    logic                       q_empty_s;
    logic                       head_v_s;
    bp_fe_packed_word_s         head_s;

    bp_fe_packer_queue queue (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enq_cnt_i  (enq_cnt_s),
        .enq0_i     (enq0_s),
        .enq1_i     (enq1_s),
        .deq_i      (word_ready_and_i),
        .head_v_o   (head_v_s),
        .head_o     (head_s),
        .free_cnt_o (free_cnt_s),
        .empty_o    (q_empty_s)
    );

    // Packing rules: decide words to enqueue and the next pending half.
    always_comb begin
        // Two free entries cover the worst case (flushed half + new word);
        // free count comes from registered occupancy so ready ignores dequeue.
        ready_s         = (free_cnt_s >= 3'd2) & ~flush_i;
        accept_s        = instr_v_i & ready_s;
        compressed_s    = (instr_i[1:0] != 2'b11);
        contig_s        = pend_v_r & (pc_i == (pend_addr_r + half_step_lp));
        drop_word_s     = make_word(2'b01, pend_addr_r, {16'h0000, pend_data_r});
        drop_v_s        = 1'b0;
        main_v_s        = 1'b0;
        main_word_s     = '0;
        enq0_s          = '0;
        enq1_s          = '0;
        enq_cnt_s       = 2'd0;
        pend_v_nxt_s    = pend_v_r;
        pend_data_nxt_s = pend_data_r;
        pend_addr_nxt_s = pend_addr_r;

        if (accept_s) begin
            // A pending half that the new PC does not continue is emitted alone.
            drop_v_s     = pend_v_r & ~contig_s;
            pend_v_nxt_s = 1'b0;
            if (contig_s) begin
                main_v_s    = 1'b1;
                main_word_s = make_word(2'b11, pend_addr_r, {instr_i[15:0], pend_data_r});
                if (compressed_s) begin
                    pend_v_nxt_s = 1'b0;
                end else begin
                    pend_v_nxt_s    = 1'b1;
                    pend_data_nxt_s = instr_i[31:16];
                    pend_addr_nxt_s = pend_addr_r + word_step_lp;
                end
            end else if (!pc_i[1]) begin
                if (compressed_s) begin
                    pend_v_nxt_s    = 1'b1;
                    pend_data_nxt_s = instr_i[15:0];
                    pend_addr_nxt_s = pc_i;
                end else begin
                    main_v_s    = 1'b1;
                    main_word_s = make_word(2'b11, pc_i, instr_i);
                end
            end else begin
                main_v_s    = 1'b1;
                main_word_s = make_word(2'b10, pc_i - half_step_lp, {instr_i[15:0], 16'h0000});
                if (compressed_s) begin
                    pend_v_nxt_s = 1'b0;
                end else begin
                    pend_v_nxt_s    = 1'b1;
                    pend_data_nxt_s = instr_i[31:16];
                    pend_addr_nxt_s = pc_i + half_step_lp;
                end
            end

            if (drop_v_s) begin
                enq0_s    = drop_word_s;
                enq1_s    = main_word_s;
                enq_cnt_s = main_v_s ? 2'd2 : 2'd1;
            end else begin
                enq0_s    = main_word_s;
                enq1_s    = '0;
                enq_cnt_s = main_v_s ? 2'd1 : 2'd0;
            end
        end else if (flush_i && pend_v_r && (free_cnt_s != 3'd0)) begin
            enq0_s       = drop_word_s;
            enq_cnt_s    = 2'd1;
            pend_v_nxt_s = 1'b0;
        end else begin
            enq_cnt_s = 2'd0;
        end
    end

    // Pending half register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_v_r    <= 1'b0;
            pend_data_r <= 16'h0000;
            pend_addr_r <= '0;
        end else begin
            pend_v_r    <= pend_v_nxt_s;
            pend_data_r <= pend_data_nxt_s;
            pend_addr_r <= pend_addr_nxt_s;
        end
    end

    assign instr_ready_and_o = ready_s;
    assign word_v_o          = head_v_s;
    assign word_o            = head_s.data;
    assign word_addr_o       = head_s.addr;
    assign word_mask_o       = head_s.mask;
    assign idle_o            = ~pend_v_r & q_empty_s;

`ifdef BP_FE_PACKER_RESUME_EN
    assign partial_v_o     = pend_v_r;
    assign partial_instr_o = pend_data_r;
    assign partial_pc_o    = pend_addr_r;
`else
    assign partial_v_o     = 1'b0;
    assign partial_instr_o = 16'h0000;
    assign partial_pc_o    = '0;
`endif

endmodule

// File: tb/tb_bp_fe_packer.sv
// Randomized and directed bench for bp_fe_packer against a queue-based model.
module tb_bp_fe_packer;
    import bp_fe_pkg::*;

    localparam int va_lp = vaddr_width_gp;
`ifdef BP_FE_PACKER_RESUME_EN
    localparam bit resume_en_lp = 1'b1;
`else
    localparam bit resume_en_lp = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic             instr_v_i;
    logic [31:0]      instr_i;
    logic [va_lp-1:0] pc_i;
    logic             instr_ready_and_o;
    logic             flush_i;
    logic             word_v_o;
    logic [31:0]      word_o;
    logic [va_lp-1:0] word_addr_o;
    logic [1:0]       word_mask_o;
    logic             word_ready_and_i;
    logic             partial_v_o;
    logic [15:0]      partial_instr_o;
    logic [va_lp-1:0] partial_pc_o;
    logic             idle_o;

    bp_fe_packer dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .instr_v_i        (instr_v_i),
        .instr_i          (instr_i),
        .pc_i             (pc_i),
        .instr_ready_and_o(instr_ready_and_o),
        .flush_i          (flush_i),
        .word_v_o         (word_v_o),
        .word_o           (word_o),
        .word_addr_o      (word_addr_o),
        .word_mask_o      (word_mask_o),
        .word_ready_and_i (word_ready_and_i),
        .partial_v_o      (partial_v_o),
        .partial_instr_o  (partial_instr_o),
        .partial_pc_o     (partial_pc_o),
        .idle_o           (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: pending half plus a list of words the design should hold.
    bit                 m_pv;
    logic [15:0]        m_pd;
    logic [va_lp-1:0]   m_pa;
    bp_fe_packed_word_s exp_q[$];

    function automatic void push_word(input logic [1:0] mask, input logic [va_lp-1:0] addr,
                                      input logic [31:0] data);
        bp_fe_packed_word_s w;
        w.mask = mask;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endfunction

    function automatic void model_accept(input logic [31:0] instr, input logic [va_lp-1:0] pc);
        bit comp = (instr[1:0] != 2'b11);
        if (m_pv && pc != m_pa + 2) begin
            push_word(2'b01, m_pa, {16'h0000, m_pd});
            m_pv = 1'b0;
        end
        if (m_pv) begin
            push_word(2'b11, m_pa, {instr[15:0], m_pd});
            if (comp) m_pv = 1'b0;
            else begin m_pd = instr[31:16]; m_pa = m_pa + 4; end
        end else if (pc[1] == 1'b0) begin
            if (comp) begin m_pv = 1'b1; m_pd = instr[15:0]; m_pa = pc; end
            else push_word(2'b11, pc, instr);
        end else begin
            push_word(2'b10, pc - 2, {instr[15:0], 16'h0000});
            if (!comp) begin m_pv = 1'b1; m_pd = instr[31:16]; m_pa = pc + 2; end
        end
    endfunction

    task automatic check_outputs();
        int occ = exp_q.size();
        check_eq("ready", instr_ready_and_o, (occ <= 2) && !flush_i);
        check_eq("word_v", word_v_o, occ != 0);
        if (occ != 0) begin
            check_eq("word_data", word_o, exp_q[0].data);
            check_eq("word_addr", word_addr_o, exp_q[0].addr);
            check_eq("word_mask", word_mask_o, exp_q[0].mask);
        end
        check_eq("idle", idle_o, !m_pv && occ == 0);
        check_eq("partial_v", partial_v_o, resume_en_lp && m_pv);
        if (resume_en_lp && m_pv) begin
            check_eq("partial_instr", partial_instr_o, m_pd);
            check_eq("partial_pc", partial_pc_o, m_pa);
        end
    endtask

    // One clock: drive inputs, check current outputs, advance the model, clock.
    task automatic step(input bit rst, input bit v, input logic [31:0] instr,
                        input logic [va_lp-1:0] pc, input bit fl, input bit wr, output bit acc);
        int occ;
        reset_i = rst; instr_v_i = v; instr_i = instr; pc_i = pc;
        flush_i = fl; word_ready_and_i = wr;
        #1;
        check_outputs();
        occ = exp_q.size();
        acc = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_pv = 1'b0;
        end else begin
            acc = v && (occ <= 2) && !fl;
            if (occ != 0 && wr) void'(exp_q.pop_front());
            if (acc) model_accept(instr, pc);
            else if (fl && m_pv && occ <= 3) begin
                push_word(2'b01, m_pa, {16'h0000, m_pd});
                m_pv = 1'b0;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [va_lp-1:0] pc, input bit wr);
        bit acc;
        step(1'b0, 1'b1, instr, pc, 1'b0, wr, acc);
        check_eq("send_accepted", acc, 1'b1);
    endtask

    task automatic drain(input int n, input bit fl);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, '0, fl, 1'b1, acc);
    endtask

    initial begin
        bit               acc;
        bit               comp;
        logic [31:0]      ins;
        logic [63:0]      r64;
        logic [va_lp-1:0] next_pc;
        logic [va_lp-1:0] pc;

        reset_i = 1'b1; instr_v_i = 1'b0; instr_i = 32'h0; pc_i = '0;
        flush_i = 1'b0; word_ready_and_i = 1'b0;
        m_pv = 1'b0; m_pd = 16'h0; m_pa = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        #1;
        check_eq("rst_word_v", word_v_o, 1'b0);
        check_eq("rst_word", word_o, 32'h0);
        check_eq("rst_addr", word_addr_o, 64'h0);
        check_eq("rst_mask", word_mask_o, 2'b00);
        check_eq("rst_partial_v", partial_v_o, 1'b0);
        check_eq("rst_partial_instr", partial_instr_o, 16'h0);
        check_eq("rst_partial_pc", partial_pc_o, 64'h0);
        check_eq("rst_idle", idle_o, 1'b1);
        check_eq("rst_ready", instr_ready_and_o, 1'b1);

        // Aligned 32-bit.
        send(32'h0000_0013, 39'h1000, 1'b1);
        check_eq("al_v", word_v_o, 1'b1);
        check_eq("al_data", word_o, 32'h0000_0013);
        check_eq("al_mask", word_mask_o, 2'b11);
        check_eq("al_addr", word_addr_o, 64'h1000);
        drain(2, 1'b0);

        // Compressed pair.
        send(32'h0000_4501, 39'h2000, 1'b1);
        check_eq("cp_partial_v", partial_v_o, resume_en_lp);
        check_eq("cp_no_word", word_v_o, 1'b0);
        send(32'h0000_4585, 39'h2002, 1'b1);
        check_eq("cp_data", word_o, 32'h4585_4501);
        check_eq("cp_mask", word_mask_o, 2'b11);
        check_eq("cp_addr", word_addr_o, 64'h2000);
        drain(2, 1'b0);

        // Straddle then flush.
        send(32'h0000_4501, 39'h3000, 1'b1);
        send(32'h00A0_0513, 39'h3002, 1'b1);
        check_eq("st_data", word_o, 32'h0513_4501);
        check_eq("st_mask", word_mask_o, 2'b11);
        if (resume_en_lp) check_eq("st_partial", partial_instr_o, 16'h00A0);
        drain(1, 1'b1);
        check_eq("fl_data", word_o, 32'h0000_00A0);
        check_eq("fl_mask", word_mask_o, 2'b01);
        check_eq("fl_addr", word_addr_o, 64'h3004);
        drain(2, 1'b0);

        // Misaligned start.
        send(32'h1234_5677, 39'h4002, 1'b1);
        check_eq("ma_data", word_o, 32'h5677_0000);
        check_eq("ma_mask", word_mask_o, 2'b10);
        check_eq("ma_addr", word_addr_o, 64'h4000);
        if (resume_en_lp) check_eq("ma_ppc", partial_pc_o, 64'h4004);
        drain(3, 1'b1);

        // Discontinuity: two words from one acceptance.
        send(32'h0000_4501, 39'h5000, 1'b0);
        send(32'h0000_0013, 39'h6000, 1'b0);
        check_eq("dc_data0", word_o, 32'h0000_4501);
        check_eq("dc_mask0", word_mask_o, 2'b01);
        check_eq("dc_addr0", word_addr_o, 64'h5000);
        drain(1, 1'b0);
        check_eq("dc_data1", word_o, 32'h0000_0013);
        check_eq("dc_mask1", word_mask_o, 2'b11);
        check_eq("dc_addr1", word_addr_o, 64'h6000);
        drain(2, 1'b0);

        // Address wrap at the top of the virtual space.
        send(32'h0000_4501, {va_lp{1'b1}} - 39'd3, 1'b1);
        send(32'h00A0_0513, {va_lp{1'b1}} - 39'd1, 1'b1);
        if (resume_en_lp) check_eq("wr_ppc", partial_pc_o, 64'h0);
        drain(4, 1'b1);

        // Backpressure then reset mid-stream.
        send(32'h0000_0013, 39'h7000, 1'b0);
        send(32'h0000_0013, 39'h7004, 1'b0);
        send(32'h0000_0013, 39'h7008, 1'b0);
        check_eq("bp_ready", instr_ready_and_o, 1'b0);
        step(1'b0, 1'b1, 32'h0000_4501, 39'h700C, 1'b0, 1'b0, acc);
        check_eq("bp_blocked", acc, 1'b0);
        step(1'b1, 1'b0, 32'h0, '0, 1'b0, 1'b0, acc);
        check_eq("rs_idle", idle_o, 1'b1);
        check_eq("rs_word_v", word_v_o, 1'b0);

        // Randomized stream.
        next_pc = 39'h10000;
        for (int c = 0; c < 4000; c++) begin
            comp = $urandom_range(0, 1) == 1;
            ins  = $urandom;
            ins[1:0] = comp ? 2'($urandom_range(0, 2)) : 2'b11;
            if ($urandom_range(0, 11) == 0) begin
                r64 = {$urandom, $urandom};
                next_pc = r64[va_lp-1:0];
                if ($urandom_range(0, 3) == 0) next_pc = {va_lp{1'b1}} - va_lp'(2 * $urandom_range(0, 4));
                next_pc[0] = 1'b0;
            end
            pc = next_pc;
            step($urandom_range(0, 499) == 0, $urandom_range(0, 9) < 8, ins, pc,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, acc);
            if (acc) next_pc = pc + (comp ? 39'd2 : 39'd4);
        end
        drain(6, 1'b1);
        check_eq("end_idle", idle_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_fe_packer.md
# bp_fe_packer

Instruction packer: the inverse of the FE realigner. It accepts a stream of variable-length instructions (16-bit compressed or 32-bit), each tagged with its PC, and packs their 16-bit parcels into 32-bit-aligned words with per-half valid masks. It holds a straddling upper half across words and can export that half in the realigner's resume format. It sits between commit/replay sources and any aligned instruction store, such as the replay buffer, trace memory or I$ patch path.

## Interface
- bp_params_p, e_bp_default_cfg, processor config; supplies vaddr_width_p, instr_width_gp (32) and cinstr_width_gp (16).
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- instr_v_i  in  1  input instruction valid.
- instr_i  in  instr_width_gp  instruction. Bits [1:0] != 2'b11 means compressed; bits [31:16] are ignored in that case.
- pc_i  in  vaddr_width_p  instruction PC; bit 0 is always 0.
- instr_ready_and_o  out  1  input ready. Transfer occurs on instr_v_i & instr_ready_and_o.
- flush_i  in  1  level request to emit any pending half.
- word_v_o  out  1  packed word valid.
- word_o  out  instr_width_gp  packed word; the lower half is at word_addr_o, the upper half at word_addr_o+2.
- word_addr_o  out  vaddr_width_p  word address, 4-byte aligned.
- word_mask_o  out  2  bit0 means the lower half is valid, bit1 means the upper half is valid.
- word_ready_and_i  in  1  consumer ready.
- partial_v_o  out  1  a pending half is held.
- partial_instr_o  out  cinstr_width_gp  the pending half.
- partial_pc_o  out  vaddr_width_p  address of the pending half.
- idle_o  out  1  no pending half and the queue is empty.

## Operation
- State:
  - pending register {pend_v, pend_data[15:0], pend_addr} (pend_addr is word aligned).
  - 4-entry output queue.
- The input is accepted only when the queue has ≥2 free entries and flush_i=0. The ready signal never depends on instr_v_i or pc_i.
- contig = pend_v & (pc_i == pend_addr+2). Widths are vaddr_width_p; wrap is modulo 2^vaddr_width_p.
- For each accepted instruction, evaluate the first matching rule in order. Enqueue 0, 1 or 2 words per rule, oldest first.
  1. pend_v & ~contig: enqueue {0, pend_data} mask 01 at pend_addr, clear pending, then apply rules 2–5 with pend_v=0.
  2. contig, compressed: enqueue {instr[15:0], pend_data} mask 11 at pend_addr; clear pending.
  3. contig, 32-bit: enqueue {instr[15:0], pend_data} mask 11 at pend_addr; set pending to instr[31:16] at pend_addr+4.
  4. ~pend_v, pc_i[1]=0:
     - Compressed: set pending to instr[15:0] at pc_i; enqueue nothing.
     - 32-bit: enqueue instr mask 11 at pc_i.
  5. ~pend_v, pc_i[1]=1: enqueue {instr[15:0], 16'h0} mask 10 at pc_i-2.
     - If 32-bit: also set pending to instr[31:16] at pc_i+2.
- Flush:
  - While flush_i=1 and the queue has ≥1 free entry, enqueue the pending half as {0, pend_data} mask 01 at pend_addr and clear pending.
  - Flush with no pending half is a no-op.
- Invalid masked-off halves are driven as zero.
- partial_* reflect the pending register directly, for use as a realigner redirect_resume/redirect_instr/redirect_pc source.

## Timing
- Reset values:
  - word_v_o=0; word_o, word_addr_o, word_mask_o all 0.
  - partial_v_o=0, partial_instr_o=0, partial_pc_o=0.
  - idle_o=1.
  - instr_ready_and_o=1 whenever flush_i=0.
- Latency: an enqueued word is visible on word_* the cycle after acceptance. Queue outputs are registered.
- Throughput: one instruction per cycle while the consumer holds word_ready_and_i=1.
- Simultaneous dequeue and enqueue: the free count for the ready decision uses the registered occupancy only. A same-cycle dequeue does not create space.
- word_* hold stable while word_v_o & ~word_ready_and_i.
- Queue wrap: the pointers are 2-bit and wrap naturally.
- Reset mid-operation drops the pending half and all queued words without emitting them.

## Configuration
- BP_FE_PACKER_RESUME_EN:
  - Defined: partial_* are driven from the pending register.
  - Undefined: partial_v_o, partial_instr_o and partial_pc_o are tied to 0; packing behaviour is unchanged.

## Structure
- bp_fe_pkg:
  - bp_fe_packed_word_s {mask[1:0], addr, data}.
  - Constant for queue depth 4.
- Sub-module bp_fe_packer_queue: 4-entry circular buffer accepting 0/1/2 enqueues per cycle (enq_cnt_i[1:0]) and one dequeue, with a free_cnt_o output.

## Test plan
- Aligned 32-bit: 0x00000013 at 0x1000 → word 0x00000013, mask 11, addr 0x1000, one cycle later.
- Compressed pair: 0x4501 at 0x2000, then 0x4585 at 0x2002 → one word 0x45854501, mask 11 at 0x2000; partial_v_o=1 in between.
- Straddle: 0x4501 at 0x3000, then 0x00A00513 at 0x3002 → 0x05134501 mask 11 at 0x3000. Pending 0x00A0 at 0x3004; flush_i → 0x000000A0 mask 01 at 0x3004.
- Misaligned start: 32-bit 0x12345677 at 0x4002 → 0x56770000 mask 10 at 0x4000; partial_pc_o=0x4004.
- Discontinuity: pending 0x4501 at 0x5000, then 32-bit 0x00000013 at 0x6000 → 0x00004501 mask 01 at 0x5000, followed by 0x00000013 mask 11 at 0x6000, in the same acceptance.
- Backpressure and reset: hold word_ready_and_i=0 → instr_ready_and_o drops once occupancy >2. Assert reset_i mid-stream → idle_o=1, word_v_o=0 the next cycle.
